// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles through one
// registered full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             x, y, d, br_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        // NOTE: every variable gets a hold/default value first, so no path can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        x        = a_q[0];
        y        = b_q[0];
        d        = x ^ y ^ br_q;
        br_next  = (~x & y) | (~(x ^ y) & br_q);
        res_next = {d, res_q[WIDTH-1:1]};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = res_next;
                    bout_d  = br_next;
                    // The last bit shifted in is the result MSB.
                    ovf_d   = (a_msb_q != b_msb_q) && (d != a_msb_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: driver pushes reference results into a
// scoreboard queue, a monitor pops and compares them on every done pulse.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             bin   = 1'b0;
    logic             busy, done, bout, ovf;
    logic [WIDTH-1:0] diff;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic binv, input int c);
        exp_t        e;
        logic [WIDTH:0] t;
        t         = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, binv};
        e.diff    = t[WIDTH-1:0];
        e.bout    = t[WIDTH];
        e.ovf     = (av[WIDTH-1] != bv[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
        e.acc_cyc = c;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("diff",    32'(diff), 32'(e.diff));
                check("bout",    32'(bout), 32'(e.bout));
                check("ovf",     32'(ovf),  32'(e.ovf));
                check("latency", 32'(cyc - e.acc_cyc), 32'(WIDTH));
            end
        end
    end

    // Driver: assumes the DUT is in IDLE or DONE; scrambles the inputs after accept.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic binv);
        @(negedge clk);
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(av, bv, binv, cyc));
        check("busy_on_accept", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
    endtask

    // Returns just after the edge that raises done; counts busy samples on the way.
    task automatic wait_done(output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_bout"}, 32'(bout), 32'd0);
        check({tag, "_ovf"},  32'(ovf),  32'd0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
    } vec_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   bc;
        int   done_cnt;
        vec_t vecs[5];

        vecs[0] = '{8'h00, 8'h01, 1'b0};
        vecs[1] = '{8'h10, 8'h0F, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtract with busy/done shape
        do_op(8'h5A, 8'h3C, 1'b0);
        wait_done(bc);
        check("busy_len", 32'(bc + 1), 32'(WIDTH));
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_width", 32'(done), 32'd0);

        // Borrow chain, bin and signed overflow corners
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(bc);
        end

        // start during SHIFT is ignored
        do_op(8'h33, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        bin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);

        // Back-to-back accept in the DONE cycle
        do_op(8'h05, 8'h03, 1'b0);
        check("no_idle_gap", 32'(done), 32'd0);
        wait_done(bc);

        // Held result during next SHIFT, then async reset mid-operation
        do_op(8'h5A, 8'h3C, 1'b0);
        wait_done(bc);
        do_op(8'hFF, 8'h01, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("hold_diff", 32'(diff), 32'h1E);
        check("hold_bout", 32'(bout), 32'd0);
        check("hold_ovf",  32'(ovf),  32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        sb.delete();
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("no_done_after_rst", 32'(done_cnt), 32'd0);
        do_op(8'h09, 8'h04, 1'b0);
        wait_done(bc);

        // Random regression, occasionally back-to-back
        for (int i = 0; i < 1000; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done(bc);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #2;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
